// File: rtl/seq_multiplier_if.sv
// Operand/result handshake bundle for the sequential multiplier.
// The master issues start with operands, and the slave returns busy, done and product.
interface seq_multiplier_if #(
    parameter int WIDTH = 16
);
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/seq_multiplier.sv
// Unsigned shift-and-add multiplier: one ripple-adder pass per cycle, WIDTH cycles per product.
// Also holds the ripple adder it uses as its only arithmetic element.
module adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    logic [WIDTH:0] w_carry;

    assign w_carry[0] = i_cin;

    for (genvar g = 0; g < WIDTH; g++) begin : g_fa
        assign o_sum[g]     = i_a[g] ^ i_b[g] ^ w_carry[g];
        assign w_carry[g+1] = (i_a[g] & i_b[g]) | (w_carry[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_cout = w_carry[WIDTH];
endmodule

module seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    seq_multiplier_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_mq;
    logic [WIDTH-1:0]     r_mcand;
    logic [CW-1:0]        r_count;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH-1:0]     w_add_b;
    logic [WIDTH-1:0]     w_sum;
    logic                 w_cout;
    logic [2*WIDTH-1:0]   w_shifted;
    logic                 w_load;
    logic                 w_step;
    logic                 w_last;

    assign w_add_b = r_mq[0] ? r_mcand : '0;

    adder #(.WIDTH(WIDTH)) u_adder (
        .i_a    (r_acc),
        .i_b    (w_add_b),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Carry-out becomes acc's MSB; mq's LSB has been consumed and falls off the end.
    assign w_shifted = {w_cout, w_sum, r_mq[WIDTH-1:1]};

    assign w_load = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_step = (r_state == S_RUN);
    assign w_last = w_step && (r_count == LAST);

    // Next-state decode for the IDLE/RUN/DONE sequencer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_count == LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand load, per-iteration shift/accumulate, and product capture
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc     <= '0;
            r_mq      <= '0;
            r_mcand   <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else if (w_load) begin
            r_mcand <= bus.a;
            r_mq    <= bus.b;
            r_acc   <= '0;
            r_count <= '0;
        end else if (w_step) begin
            r_acc   <= w_shifted[2*WIDTH-1:WIDTH];
            r_mq    <= w_shifted[WIDTH-1:0];
            r_count <= r_count + CW'(1);
            if (w_last) begin
                r_product <= w_shifted;
            end else begin
                r_product <= r_product;
            end
        end else begin
            r_product <= r_product;
        end
    end

    assign bus.busy    = (r_state == S_RUN);
    assign bus.done    = (r_state == S_DONE);
    assign bus.product = r_product;
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=16: table of products plus
// hand sequences for back-to-back starts, ignored starts and reset aborts.
module tb_seq_multiplier;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    seq_multiplier_if #(.WIDTH(W)) bus ();

    seq_multiplier #(.WIDTH(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one rising edge, then settle just after it for driving and sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        tick();
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
    endtask

    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_cnt++;
            tick();
            lat++;
        end
    endtask

    vec_t vecs[10];
    int   lat;
    int   bcnt;
    int   dcnt;
    logic [2*W-1:0] held;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{16'h0000, 16'h0000, 32'h0000_0000};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
        vecs[2] = '{16'hC000, 16'h7000, 32'h5400_0000};
        vecs[3] = '{16'h0003, 16'h0005, 32'h0000_000F};
        vecs[4] = '{16'h1234, 16'h0010, 32'h0001_2340};
        vecs[5] = '{16'h0002, 16'h8000, 32'h0001_0000};
        vecs[6] = '{16'h0001, 16'hFFFF, 32'h0000_FFFF};
        vecs[7] = '{16'h8000, 16'h8000, 32'h4000_0000};
        vecs[8] = '{16'h00FF, 16'h0101, 32'h0000_FFFF};
        vecs[9] = '{16'h1234, 16'h5678, 32'h0626_0060};

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst       = 1'b1;
        tick();
        tick();
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_product", 64'(bus.product), 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_done(lat, bcnt);
            check($sformatf("latency[%0d]", i), 64'(lat), 64'd16);
            check($sformatf("busy_cycles[%0d]", i), 64'(bcnt), 64'd16);
            check($sformatf("product[%0d]", i), 64'(bus.product), 64'(vecs[i].exp));
            tick();
            check($sformatf("done_pulse[%0d]", i), 64'(bus.done), 64'd0);
            check($sformatf("idle_busy[%0d]", i), 64'(bus.busy), 64'd0);
            check($sformatf("product_held[%0d]", i), 64'(bus.product), 64'(vecs[i].exp));
        end

        // Back-to-back: second start issued in the DONE cycle
        start_op(16'hC000, 16'h7000);
        wait_done(lat, bcnt);
        check("b2b_first_product", 64'(bus.product), 64'h5400_0000);
        start_op(16'h0003, 16'h0005);
        check("b2b_no_idle_busy", 64'(bus.busy), 64'd1);
        check("b2b_no_idle_done", 64'(bus.done), 64'd0);
        check("b2b_product_held_run", 64'(bus.product), 64'h5400_0000);
        wait_done(lat, bcnt);
        check("b2b_second_latency", 64'(lat), 64'd16);
        check("b2b_second_product", 64'(bus.product), 64'h0000_000F);
        tick();

        // Start during RUN is dropped
        start_op(16'h1234, 16'h0010);
        for (int k = 0; k < 4; k++) tick();
        bus.start = 1'b1;
        bus.a     = 16'hFFFF;
        bus.b     = 16'hFFFF;
        tick();
        bus.start = 1'b0;
        wait_done(lat, bcnt);
        check("ignored_start_latency", 64'(lat + 5), 64'd16);
        check("ignored_start_product", 64'(bus.product), 64'h0001_2340);
        dcnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.done || bus.busy) dcnt++;
        end
        check("ignored_start_no_second_op", 64'(dcnt), 64'd0);
        check("ignored_start_product_held", 64'(bus.product), 64'h0001_2340);

        // Reset pulsed mid-operation aborts it
        start_op(16'hFFFF, 16'hFFFF);
        for (int k = 0; k < 7; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_product", 64'(bus.product), 64'd0);
        dcnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.done) dcnt++;
        end
        check("abort_no_done", 64'(dcnt), 64'd0);
        check("abort_product_stays_zero", 64'(bus.product), 64'd0);
        start_op(16'h0002, 16'h8000);
        wait_done(lat, bcnt);
        check("after_abort_latency", 64'(lat), 64'd16);
        check("after_abort_product", 64'(bus.product), 64'h0001_0000);
        tick();

        // Reset held with start asserted keeps the block idle
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 16'hFFFF;
        bus.b     = 16'hFFFF;
        bcnt = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.busy || bus.done) bcnt++;
        end
        check("rst_held_idle", 64'(bcnt), 64'd0);
        check("rst_held_product", 64'(bus.product), 64'd0);
        bus.start = 1'b0;
        rst       = 1'b0;
        tick();
        check("rst_release_idle", 64'(bus.busy), 64'd0);
        start_op(16'h1234, 16'h5678);
        check("rst_release_accept", 64'(bus.busy), 64'd1);
        wait_done(lat, bcnt);
        check("rst_release_latency", 64'(lat), 64'd16);
        check("rst_release_product", 64'(bus.product), 64'h0626_0060);
        held = bus.product;
        tick();
        check("rst_release_done_pulse", 64'(bus.done), 64'd0);
        check("rst_release_product_held", 64'(bus.product), 64'(held));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Multi-cycle unsigned shift-and-add multiplier.
- Instantiates the existing parameterised ripple adder, `adder #(WIDTH)`, as its only arithmetic element. The block drives the adder's operands and carry-in, then consumes its sum and carry-out every iteration.
- Takes two WIDTH-bit operands with a start/done handshake and returns a 2*WIDTH-bit product after WIDTH iterations.
- Sits between operand registers and result consumers in the datapath exercises.

Parameters:
- WIDTH, 16, operand width in bits; legal range is WIDTH >= 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset; one clock, synchronous, active-high.
- start  input  1  request to load a and b and begin a multiplication.
- a  input  WIDTH  multiplicand; sampled only on the accepting edge.
- b  input  WIDTH  multiplier; sampled only on the accepting edge.
- busy  output  1  high while iterations are in progress.
- done  output  1  one-cycle pulse; product is valid from this cycle on.
- product  output  2*WIDTH  registered result; held until the next done.

Behaviour:
- Reset:
  - Synchronous: rst high at a rising edge forces state=IDLE, busy=0, done=0, product=0, and clears all internal registers (acc, mq, mcand, count).
  - rst takes priority over start and over any iteration in flight.
  - An aborted operation produces no done and leaves product=0.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 at edge N → mcand<=a, mq<=b, acc<=0, count<=0, state<=RUN. start=0 → stay in IDLE.
  - RUN: one iteration per edge.
    - Adder inputs: operand A = acc. Operand B = mcand if mq[0]=1, else 0. Carry-in = 0.
    - Update: {acc, mq} <= {carry_out, sum, mq} >> 1; this is a (2*WIDTH+1)-bit right shift, keeping the low 2*WIDTH bits.
    - count <= count+1.
    - When count = WIDTH-1 at an edge: perform the last iteration, load product with the post-shift {acc, mq}, and set state <= DONE.
  - DONE: lasts exactly one cycle.
    - start=1 → reload operands and go to RUN (back-to-back; same actions as in IDLE).
    - start=0 → go to IDLE.
- Outputs:
  - busy = (state==RUN).
  - done = (state==DONE).
  - Both are decoded from registered state only.
- Timing, for start accepted at edge N:
  - busy=1 after edges N..N+WIDTH-1.
  - done=1 after edge N+WIDTH only.
  - Latency from accepting edge to done is WIDTH cycles.
- start handling:
  - start while in RUN is ignored; no queuing, and the operation in flight is unaffected.
  - a and b may change freely after the accepting edge.
- Arithmetic:
  - Unsigned only.
  - The adder carry-out must be captured as acc's new MSB before the shift. Dropping it is a defect, visible with 0xFFFF × 0xFFFF.
  - The product never overflows 2*WIDTH bits.
- product updates only on entry to DONE. It holds its value through IDLE and the following RUN until the next DONE.
- Zero operands take the same WIDTH cycles; there is no early termination.
- count is ceil(log2(WIDTH+1)) bits wide.

Test Plan (WIDTH=16, start held 1 cycle):
- a=0x0000, b=0x0000 → done exactly 16 cycles after accept, product=0x0000_0000, done high 1 cycle, busy high 16 cycles.
- a=0xFFFF, b=0xFFFF → product=0xFFFE_0001 (exercises adder carry-out capture).
- a=0xC000, b=0x7000 → product=0x5400_0000; then a=0x0003, b=0x0005 issued with start in the DONE cycle → second done 16 cycles later, product=0x0000_000F, no IDLE cycle between the two operations.
- a=0x1234, b=0x0010 accepted; start pulsed with a=0xFFFF, b=0xFFFF at cycle 5 of RUN → single done, product=0x0001_2340, second request dropped.
- a=0xFFFF, b=0xFFFF accepted, rst pulsed at cycle 8 → next cycle busy=0, done=0, product=0; no done within 20 cycles. A new start with a=0x0002, b=0x8000 → product=0x0001_0000.
- rst held with start=1 → stays IDLE, busy=0; release rst → next start accepted normally.
